// File: rtl/coherent_bus_n.sv
// Snooping bus: NUM_CPUS direct-mapped write-back caches over one shared memory, MSI coherence, round-robin arbitration.
// Define COHERENT_BUS_MESI_EN to add the Exclusive state (MESI): lone read misses install E, E->M upgrades are silent.
module coherent_bus_n #(
  parameter int NUM_CPUS = 2,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 4,
  parameter int LINES    = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_CPUS-1:0]        execute,
  input  logic [NUM_CPUS-1:0]        instruction,
  input  logic [NUM_CPUS*ADDR_W-1:0] address,
  input  logic [NUM_CPUS*DATA_W-1:0] data_in,
  output logic [NUM_CPUS*DATA_W-1:0] data_out,
  output logic [NUM_CPUS-1:0]        done,
  output logic [NUM_CPUS*2-1:0]      line_state,
  output logic                       busy
);

  localparam int CPU_W     = $clog2(NUM_CPUS);
  localparam int IDX_W     = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int MEM_WORDS = 1 << ADDR_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b11;
`ifdef COHERENT_BUS_MESI_EN
  localparam logic [1:0] ST_E = 2'b10;
  localparam int CNT_W = $clog2(NUM_CPUS + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVICT,
    S_SNOOP,
    S_FILL,
    S_COMPLETE
  } fsm_e;

  fsm_e fsm_q, fsm_d;

  // Request capture
  logic [NUM_CPUS-1:0] exec_q;
  logic [NUM_CPUS-1:0] pend_q;
  logic [NUM_CPUS-1:0] op_q;
  logic [ADDR_W-1:0]   req_addr_q [NUM_CPUS];
  logic [DATA_W-1:0]   req_data_q [NUM_CPUS];
  logic [DATA_W-1:0]   dout_q     [NUM_CPUS];
  logic [NUM_CPUS-1:0] done_q;

  // Caches keep the full line address (tag and index) so victim write-back needs no reassembly
  logic [1:0]          st_q        [NUM_CPUS][LINES];
  logic [ADDR_W-1:0]   line_addr_q [NUM_CPUS][LINES];
  logic [DATA_W-1:0]   line_data_q [NUM_CPUS][LINES];
  logic [DATA_W-1:0]   mem_q       [MEM_WORDS];

  logic [CPU_W-1:0]    rr_q;
  logic [CPU_W-1:0]    cur_q;
  logic                miss_q;
`ifdef COHERENT_BUS_MESI_EN
  logic [CNT_W-1:0]    shr_cnt_q;
`endif

  logic [NUM_CPUS-1:0] rise;
  logic                gnt_vld;
  logic [CPU_W-1:0]    gnt_id;
  logic                cur_op;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_data;
  logic [IDX_W-1:0]    cur_idx;
  logic [1:0]          cur_st;
  logic                cur_hit;
  logic [NUM_CPUS-1:0] hold;
  logic                wb_vld;
  logic [DATA_W-1:0]   wb_dat;
  logic [1:0]          rd_fill_st;
  logic [CPU_W-1:0]    rr_next;

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return IDX_W'(int'(a) % LINES);
  endfunction

  assign rise     = execute & ~exec_q;
  assign busy     = (fsm_q != S_IDLE);
  assign done     = done_q;
  assign cur_op   = op_q[cur_q];
  assign cur_addr = req_addr_q[cur_q];
  assign cur_data = req_data_q[cur_q];
  assign cur_idx  = idx_of(cur_addr);
  assign cur_st   = st_q[cur_q][cur_idx];
  assign cur_hit  = (cur_st != ST_I) && (line_addr_q[cur_q][cur_idx] == cur_addr);
  assign rr_next  = CPU_W'((int'(cur_q) + 1) % NUM_CPUS);

`ifdef COHERENT_BUS_MESI_EN
  assign rd_fill_st = (shr_cnt_q == '0) ? ST_E : ST_S;
`else
  assign rd_fill_st = ST_S;
`endif

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NUM_CPUS; k++) begin
      if (!gnt_vld && pend_q[(int'(rr_q) + k) % NUM_CPUS]) begin
        gnt_vld = 1'b1;
        gnt_id  = CPU_W'((int'(rr_q) + k) % NUM_CPUS);
      end
    end
  end

  // Other caches holding the requested address; at most one of them can be M
  always_comb begin
    hold   = '0;
    wb_vld = 1'b0;
    wb_dat = '0;
    for (int j = 0; j < NUM_CPUS; j++) begin
      if ((CPU_W'(j) != cur_q) && (st_q[j][cur_idx] != ST_I) &&
          (line_addr_q[j][cur_idx] == cur_addr)) begin
        hold[j] = 1'b1;
        if (st_q[j][cur_idx] == ST_M) begin
          wb_vld = 1'b1;
          wb_dat = line_data_q[j][cur_idx];
        end
      end
    end
  end

  always_comb begin
    line_state = '0;
    data_out   = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      line_state[i*2 +: 2]          = st_q[i][idx_of(req_addr_q[i])];
      data_out[i*DATA_W +: DATA_W] = dout_q[i];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) fsm_q <= S_IDLE;
    else         fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:   if (gnt_vld) fsm_d = S_LOOKUP;
      S_LOOKUP: begin
        if (cur_hit) begin
          if (!cur_op)              fsm_d = S_COMPLETE;
          else if (cur_st == ST_M)  fsm_d = S_COMPLETE;
`ifdef COHERENT_BUS_MESI_EN
          else if (cur_st == ST_E)  fsm_d = S_COMPLETE;
`endif
          else                      fsm_d = S_SNOOP;
        end else if (cur_st == ST_M) begin
          fsm_d = S_EVICT;
        end else begin
          fsm_d = S_SNOOP;
        end
      end
      S_EVICT:    fsm_d = S_SNOOP;
      S_SNOOP:    fsm_d = miss_q ? S_FILL : S_COMPLETE;
      S_FILL:     fsm_d = S_COMPLETE;
      S_COMPLETE: fsm_d = S_IDLE;
      default:    fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      exec_q <= '0;
      pend_q <= '0;
      op_q   <= '0;
      done_q <= '0;
      rr_q   <= '0;
      cur_q  <= '0;
      miss_q <= 1'b0;
`ifdef COHERENT_BUS_MESI_EN
      shr_cnt_q <= '0;
`endif
      for (int i = 0; i < NUM_CPUS; i++) begin
        req_addr_q[i] <= '0;
        req_data_q[i] <= '0;
        dout_q[i]     <= '0;
        for (int l = 0; l < LINES; l++) begin
          st_q[i][l]        <= ST_I;
          line_addr_q[i][l] <= '0;
          line_data_q[i][l] <= '0;
        end
      end
      for (int m = 0; m < MEM_WORDS; m++) mem_q[m] <= '0;
    end else begin
      exec_q <= execute;
      for (int i = 0; i < NUM_CPUS; i++) begin
        if (rise[i] && !pend_q[i] && !(busy && (cur_q == CPU_W'(i)))) begin
          pend_q[i]     <= 1'b1;
          op_q[i]       <= instruction[i];
          req_addr_q[i] <= address[i*ADDR_W +: ADDR_W];
          req_data_q[i] <= data_in[i*DATA_W +: DATA_W];
          done_q[i]     <= 1'b0;
        end
      end

      case (fsm_q)
        S_IDLE: begin
          if (gnt_vld) begin
            pend_q[gnt_id] <= 1'b0;
            cur_q          <= gnt_id;
          end
        end
        S_LOOKUP: miss_q <= !cur_hit;
        S_EVICT: begin
          mem_q[line_addr_q[cur_q][cur_idx]] <= line_data_q[cur_q][cur_idx];
          st_q[cur_q][cur_idx]               <= ST_I;
        end
        S_SNOOP: begin
          if (wb_vld) mem_q[cur_addr] <= wb_dat;
          for (int j = 0; j < NUM_CPUS; j++) begin
            if (hold[j]) st_q[j][cur_idx] <= cur_op ? ST_I : ST_S;
          end
`ifdef COHERENT_BUS_MESI_EN
          shr_cnt_q <= CNT_W'($countones(hold));
`endif
        end
        S_FILL: begin
          line_addr_q[cur_q][cur_idx] <= cur_addr;
          line_data_q[cur_q][cur_idx] <= mem_q[cur_addr];
        end
        S_COMPLETE: begin
          if (cur_op) begin
            line_addr_q[cur_q][cur_idx] <= cur_addr;
            line_data_q[cur_q][cur_idx] <= cur_data;
            st_q[cur_q][cur_idx]        <= ST_M;
          end else begin
            dout_q[cur_q] <= line_data_q[cur_q][cur_idx];
            if (miss_q) st_q[cur_q][cur_idx] <= rd_fill_st;
          end
          done_q[cur_q] <= 1'b1;
          rr_q          <= rr_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coherent_bus_n.sv
// Directed bench for coherent_bus_n with default parameters; expected values are hand-derived.
module tb_coherent_bus_n;
  localparam int N  = 2;
  localparam int AW = 3;
  localparam int DW = 4;
`ifdef COHERENT_BUS_MESI_EN
  localparam int LS_ALONE = 2;
  localparam int LAT_WR_CLEAN = 2;
`else
  localparam int LS_ALONE = 1;
  localparam int LAT_WR_CLEAN = 3;
`endif

  logic            clock = 1'b0;
  logic            resetn;
  logic [N-1:0]    execute;
  logic [N-1:0]    instruction;
  logic [N*AW-1:0] address;
  logic [N*DW-1:0] data_in;
  logic [N*DW-1:0] data_out;
  logic [N-1:0]    done;
  logic [N*2-1:0]  line_state;
  logic            busy;

  int checks = 0;
  int errors = 0;

  coherent_bus_n #(.NUM_CPUS(N), .ADDR_W(AW), .DATA_W(DW), .LINES(4)) dut (
    .clock(clock), .resetn(resetn), .execute(execute), .instruction(instruction),
    .address(address), .data_in(data_in), .data_out(data_out), .done(done),
    .line_state(line_state), .busy(busy)
  );

  always #5 clock = ~clock;

  // Main sequence: cpu, op, address, data, latency, read data, line states, one memory word
  int v_cpu [7] = '{0, 1, 1, 0, 0, 0, 1};
  int v_op  [7] = '{1, 0, 1, 0, 1, 0, 0};
  int v_adr [7] = '{5, 5, 5, 5, 1, 5, 1};
  int v_dat [7] = '{9, 0, 3, 0, 6, 0, 0};
  int v_lat [7] = '{4, 4, 3, 4, 4, 5, 4};
  int v_dout[7] = '{0, 9, 0, 3, 0, 3, 6};
  int v_ls0 [7] = '{3, 1, 0, 1, 3, 1, 1};
  int v_ls1 [7] = '{1, 1, 3, 1, 1, 1, LS_ALONE};
  int v_ma  [7] = '{5, 5, 5, 5, 1, 1, 1};
  int v_mv  [7] = '{0, 9, 9, 3, 0, 6, 6};
  int t_t0  [2] = '{6, 4};
  int t_t1  [2] = '{11, 7};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    execute = '0;
    resetn  = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  // Returns clocks from grant to done (capture edge and grant edge excluded), -1 on timeout
  task automatic run_op(input int cpu, input int op, input int a, input int d, output int lat);
    int n;
    n = 0;
    @(negedge clock);
    instruction[cpu]       = (op != 0);
    address[cpu*AW +: AW]  = AW'(a);
    data_in[cpu*DW +: DW]  = DW'(d);
    execute[cpu]           = 1'b1;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!done[cpu] && n < 60);
    lat = done[cpu] ? n - 2 : -1;
    @(negedge clock);
    execute[cpu] = 1'b0;
  endtask

  initial begin
    int lat;
    int t0;
    int t1;
    resetn = 1'b0; execute = '0; instruction = '0; address = '0; data_in = '0;
    do_reset();
    #1;
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_line_state", 32'(line_state), 0);

    // Simultaneous reads of addr 2, twice: CPU0 wins both times
    for (int r = 0; r < 2; r++) begin
      @(negedge clock);
      instruction = '0;
      address     = {3'd2, 3'd2};
      execute     = 2'b11;
      t0 = -1;
      t1 = -1;
      for (int n = 1; n <= 40 && (t0 < 0 || t1 < 0); n++) begin
        @(posedge clock);
        #1;
        if (t0 < 0 && done[0]) t0 = n;
        if (t1 < 0 && done[1]) t1 = n;
      end
      chk($sformatf("tie%0d_cpu0_edge", r), t0, t_t0[r]);
      chk($sformatf("tie%0d_cpu1_edge", r), t1, t_t1[r]);
      chk($sformatf("tie%0d_data_out", r), 32'(data_out), 0);
      @(negedge clock);
      execute = '0;
    end

    for (int k = 0; k < 7; k++) begin
      run_op(v_cpu[k], v_op[k], v_adr[k], v_dat[k], lat);
      chk($sformatf("v%0d_latency", k), lat, v_lat[k]);
      if (v_op[k] == 0)
        chk($sformatf("v%0d_read_data", k), 32'(data_out[v_cpu[k]*DW +: DW]), v_dout[k]);
      chk($sformatf("v%0d_state_cpu0", k), 32'(line_state[1:0]), v_ls0[k]);
      chk($sformatf("v%0d_state_cpu1", k), 32'(line_state[3:2]), v_ls1[k]);
      chk($sformatf("v%0d_mem", k), 32'(dut.mem_q[v_ma[k]]), v_mv[k]);
    end

    // Reset while a write miss sits in SNOOP
    @(negedge clock);
    instruction[0] = 1'b1;
    address[2:0]   = 3'd6;
    data_in[3:0]   = 4'd7;
    execute[0]     = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("snoop_busy", 32'(busy), 1);
    resetn = 1'b0;
    #1;
    chk("midrst_data_out", 32'(data_out), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_line_state", 32'(line_state), 0);
    chk("midrst_mem1", 32'(dut.mem_q[1]), 0);
    chk("midrst_mem5", 32'(dut.mem_q[5]), 0);
    @(negedge clock);
    execute = '0;
    @(negedge clock);
    resetn = 1'b1;

    run_op(0, 0, 5, 0, lat);
    chk("post_rd_latency", lat, 4);
    chk("post_rd_data", 32'(data_out[3:0]), 0);
    chk("post_rd_state", 32'(line_state[1:0]), LS_ALONE);
    run_op(0, 1, 5, 4, lat);
    chk("post_wr_latency", lat, LAT_WR_CLEAN);
    chk("post_wr_state", 32'(line_state[1:0]), 3);
    run_op(0, 0, 5, 0, lat);
    chk("own_rd_latency", lat, 2);
    chk("own_rd_data", 32'(data_out[3:0]), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/coherent_bus_n.md
Name: coherent_bus_n

Overview:
- Parametrised successor to the two-CPU snooping bus. It serves NUM_CPUS processors, each with a private direct-mapped write-back cache, over one shared memory.
- Coherence is MSI, or MESI when the optional feature is compiled in.
- It sits under the board-level top: CPU requests come from switches, and data and line state drive the displays and LEDs.
- Round-robin arbitration serialises all bus transactions, one at a time.

Parameters:
- NUM_CPUS, 2, number of CPU ports (2..8).
- ADDR_W, 3, word-address width; shared memory holds 2**ADDR_W words.
- DATA_W, 4, data word width.
- LINES, 4, cache lines per CPU (power of two, at most 2**ADDR_W); one word per line.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- execute  in  NUM_CPUS  per-CPU request level; a rising edge launches an operation.
- instruction  in  NUM_CPUS  per-CPU op: 0 = read, 1 = write.
- address  in  NUM_CPUS*ADDR_W  per-CPU address, CPU i at [i*ADDR_W +: ADDR_W].
- data_in  in  NUM_CPUS*DATA_W  per-CPU write data.
- data_out  out  NUM_CPUS*DATA_W  per-CPU read result, registered.
- done  out  NUM_CPUS  per-CPU completion flag, sticky.
- line_state  out  NUM_CPUS*2  state of the line each CPU's current address indexes, combinational from registers. Encoding: I=00, S=01, E=10, M=11.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (resetn low, asynchronous):
  - All cache lines go to I, with tags and data 0.
  - Memory words clear to 0.
  - data_out=0, done=0, busy=0.
  - Pending flags clear, round-robin pointer selects CPU0, FSM goes to IDLE.
  - Reset mid-operation abandons the transaction; no partial write survives.
- Request capture:
  - execute is registered once for edge detection.
  - On a rising edge for CPU i with no pending op of its own, set pend[i], latch its op/address/data, and clear done[i] in the same cycle.
  - Edges while pend[i] is set, or while CPU i is the active requester, are ignored.
- Address split:
  - index = addr[log2(LINES)-1:0].
  - tag = remaining upper bits (zero width allowed when LINES = 2**ADDR_W).
- Arbitration:
  - In IDLE, grant the first set pend bit, searching from (last grant + 1) mod NUM_CPUS.
  - Simultaneous requests are served in that order.
  - The grant clears pend for the winner.
- FSM IDLE -> LOOKUP -> {COMPLETE | EVICT | SNOOP}:
  - LOOKUP, hit, rule 1: a read hit in S/E/M goes to COMPLETE.
  - LOOKUP, hit, rule 2: a write hit in M goes to COMPLETE.
  - LOOKUP, hit, rule 3: a write hit in E (MESI only) goes to COMPLETE with E->M and no bus traffic.
  - LOOKUP, write hit in S: go to SNOOP as an upgrade, with no fill.
  - LOOKUP, miss: if the victim line is M, go to EVICT; otherwise go to SNOOP.
  - EVICT (1 cycle): write the victim data to memory at {victim tag, index}, victim goes to I, then SNOOP.
  - SNOOP (1 cycle): every other cache holding the tag at that index responds. On a read: M writes back to memory and goes to S; E goes to S. On a write: M writes back; every holder goes to I. The sharer count is recorded.
  - SNOOP next state: FILL on a miss, COMPLETE on an upgrade.
  - FILL (1 cycle): load the line from memory. The memory value includes any write-back from that same SNOOP, forwarded without waiting a cycle.
  - COMPLETE (1 cycle):
    - Read: data_out[i] = line data; new state is S, or E under MESI when no sharers were recorded.
    - Write: line data = data_in; state M. Memory is not updated (write-back).
    - Set done[i], advance the RR pointer, return to IDLE.
- Latency, counted in clocks from the grant cycle to done high: hit = 2, clean miss or upgrade = 3 or 4, dirty-victim miss = 5.
- done[i] stays high until CPU i's next rising edge is captured.
- A CPU's own write immediately visible to its next read is required; reads by other CPUs always return the latest write.

Optional Feature:
- COHERENT_BUS_MESI_EN defined: E state enabled. A read miss with zero sharers installs E; a write hit in E upgrades silently to M.
- COHERENT_BUS_MESI_EN undefined: pure MSI. Encoding 10 never appears; a read miss always installs S.

Test Plan (defaults):
- CPU0 write addr 5 data 9 -> done[0] after 4 clocks from grant; line_state CPU0 = M; memory[5] still 0.
- Then CPU1 read addr 5 -> CPU0 writes back, memory[5]=9, both lines S, data_out CPU1 = 9, done[1] set.
- Then CPU1 write addr 5 data 3 (upgrade) -> CPU0 line I; CPU1 M; CPU0 read addr 5 returns 3.
- Both execute rise in the same cycle after reset -> CPU0 is served first, CPU1 next. A repeat tie grants CPU0 first again, because the pointer has advanced to 0.
- CPU0 has addr 1 in M (data 6), then reads addr 5 (same index) -> EVICT writes memory[1]=6; done in 5 clocks; a later read of addr 1 returns 6.
- resetn pulsed low during SNOOP -> all outputs 0 and all lines I at once; a new read of addr 5 returns 0. With COHERENT_BUS_MESI_EN, a lone read installs E (10) and a following write produces no snoop (2-clock latency).
